ysyx_23060124_mdu: RTL and testbench

YSYX_23060124_MDU -- requirements
Module: ysyx_23060124_mdu

---
 rtl/ysyx_23060124_mdu.sv | 129 ++++++++++++
 tb/tb_ysyx_23060124_mdu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_mdu.sv
// ysyx_23060124_mdu: iterative RV M-extension multiply/divide unit (radix-2 shift-add / restoring divide).
// Define YSYX_23060124_MDU_FAST_MUL_EN to complete multiplies with a single-cycle combinational product.
module ysyx_23060124_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      opt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int CW = $clog2(XLEN) + 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] p_q, p_d;
    logic [XLEN-1:0]   a_q, a_d, res_q, res_d;
    logic [2:0]        opt_q, opt_d;
    logic              neg_q, neg_d;

    logic              sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] step;

    // Both ops run on magnitudes; the sign is restored when the result is formed.
    assign sa       = src1[XLEN-1] && (opt[2] ? !opt[0] : (opt[0] ^ opt[1]));
    assign sb       = src2[XLEN-1] && (opt == 3'b001 || opt == 3'b100 || opt == 3'b110);
    assign mag1     = sa ? -src1 : src1;
    assign mag2     = sb ? -src2 : src2;
    assign div_zero = opt[2] && src2 == '0;
    assign div_ovf  = opt[2] && !opt[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;

    // p_q holds {hi, lo}: {partial sum, multiplier} or {remainder, quotient/dividend}.
    assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    assign div_rem  = p_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_rem - {1'b0, a_q};
    assign step     = opt_q[2] ? (div_diff[XLEN] ? {div_rem[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                                                 : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1})
                               : {mul_sum, p_q[XLEN-1:1]};

`ifdef YSYX_23060124_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_p;
    assign fast_p = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

    function automatic logic [XLEN-1:0] fin(input logic [2*XLEN-1:0] p, input logic neg, input logic [2:0] op);
        logic [XLEN-1:0]   v;
        logic [2*XLEN-1:0] pp;
        v  = op[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
        pp = neg ? -p : p;
        return op[2] ? (neg ? -v : v) : (op == 3'b000 ? pp[XLEN-1:0] : pp[2*XLEN-1:XLEN]);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        opt_d   = opt_q;
        neg_d   = neg_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                opt_d = opt;
                a_d   = opt[2] ? mag2 : mag1;
                p_d   = {{XLEN{1'b0}}, opt[2] ? mag1 : mag2};
                neg_d = (opt[2] && opt[1]) ? sa : sa ^ sb;
                cnt_d = CW'(XLEN);
                if (div_zero) begin
                    res_d   = opt[1] ? src1 : '1;
                    state_d = DONE;
                end else if (div_ovf) begin
                    res_d   = opt[1] ? '0 : src1;
                    state_d = DONE;
`ifdef YSYX_23060124_MDU_FAST_MUL_EN
                end else if (!opt[2]) begin
                    res_d   = fin(fast_p, sa ^ sb, opt);
                    state_d = DONE;
`endif
                end else begin
                    state_d = CALC;
                end
            end
        end else if (state_q == CALC) begin
            p_d   = step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                res_d   = fin(step, neg_q, opt_q);
                state_d = DONE;
            end
        end else if (out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            opt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            opt_q   <= opt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign res       = res_q;
endmodule

// File: tb/tb_ysyx_23060124_mdu.sv
// tb_ysyx_23060124_mdu: directed vectors, corner sequences and random ops against an arithmetic reference model.
module tb_ysyx_23060124_mdu;
    logic        clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [31:0] src1 = '0, src2 = '0, res;
    logic [2:0]  opt = '0;
    int          checks = 0, errors = 0;

`ifdef YSYX_23060124_MDU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tv[11];

    ysyx_23060124_mdu #(.XLEN(32)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .opt(opt), .out_valid(out_valid), .out_ready(out_ready), .res(res)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          p;
        longint unsigned up;
        int              ia = a;
        int              ib = b;
        logic [31:0]     r;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(ia % ib);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
        return op[2] ? 33 : ML;
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output int lat, output logic [31:0] r);
        @(negedge clock);
        src1 = a; src2 = b; opt = op; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        r = res;
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic watch(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (out_valid) hits++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          lat, hits;
        logic [31:0] r, a, b;
        logic [2:0]  op;
        tv[0]  = '{32'd7,        32'hFFFFFFFD, 3'd0, 32'hFFFFFFEB, ML};
        tv[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, ML};
        tv[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, ML};
        tv[3]  = '{32'h80000000, 32'h80000000, 3'd1, 32'h40000000, ML};
        tv[4]  = '{32'hFFFFFFF9, 32'd2,        3'd4, 32'hFFFFFFFD, 33};
        tv[5]  = '{32'hFFFFFFF9, 32'd2,        3'd6, 32'hFFFFFFFF, 33};
        tv[6]  = '{32'h80000000, 32'd3,        3'd5, 32'h2AAAAAAA, 33};
        tv[7]  = '{32'd5,        32'd0,        3'd4, 32'hFFFFFFFF, 1};
        tv[8]  = '{32'd5,        32'd0,        3'd7, 32'd5,        1};
        tv[9]  = '{32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 1};
        tv[10] = '{32'h80000000, 32'hFFFFFFFF, 3'd6, 32'd0,        1};

        repeat (2) @(posedge clock);
        #1;
        chk("reset_res", 64'(res), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;

        foreach (tv[i]) begin
            run(tv[i].a, tv[i].b, tv[i].op, lat, r);
            chk($sformatf("vec%0d_res", i), 64'(r), 64'(tv[i].exp));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tv[i].lat));
        end

        // Result held while the consumer stalls; requests during DONE are ignored.
        @(negedge clock);
        src1 = 32'd100; src2 = 32'd7; opt = 3'd5; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("stall_lat", 64'(lat), 64'd33);
        @(negedge clock);
        src1 = 32'd9; src2 = 32'd9; opt = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            chk("stall_res", 64'(res), 64'd14);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("handshake_out_valid", 64'(out_valid), 64'd0);
        chk("handshake_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0;
        watch(40, hits);
        chk("handshake_no_accept", 64'(hits), 64'd0);

        // Flush beats accept.
        @(negedge clock);
        src1 = 32'd5; src2 = 32'd0; opt = 3'd4; in_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        chk("flush_accept_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        watch(40, hits);
        chk("flush_accept_no_result", 64'(hits), 64'd0);

        // Flush at CALC cycle 5.
        @(negedge clock);
        src1 = 32'd1000; src2 = 32'd3; opt = 3'd4; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("calc_in_ready", 64'(in_ready), 64'd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock); #1;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        flush = 1'b0;
        watch(40, hits);
        chk("flush_no_result", 64'(hits), 64'd0);

        run(32'd100, 32'd7, 3'd5, lat, r);
        chk("pre_reset_res", 64'(r), 64'd14);

        // Reset at CALC cycle 5 of a new request.
        @(negedge clock);
        src1 = 32'd1000; src2 = 32'd3; opt = 3'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_res", 64'(res), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        watch(40, hits);
        chk("midreset_no_result", 64'(hits), 64'd0);

        for (int i = 0; i < 60; i++) begin
            a  = pick();
            b  = pick();
            op = 3'($urandom_range(0, 7));
            run(a, b, op, lat, r);
            chk($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), 64'(r), 64'(model(a, b, op)));
            chk($sformatf("rand%0d_lat", i), 64'(lat), 64'(exp_lat(a, b, op)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
